// File: rtl/alarm_time_keeper.sv
// Time-of-day keeper for the alarm clock: BCD HHMM clock with minute prescaler,
// alarm register, show-alarm sampling and keypad digit entry for both times.
module alarm_time_keeper #(
  parameter int unsigned CLKS_PER_MIN = 15360
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  key,
  input  logic        key_valid,
  input  logic        load_time,
  input  logic        load_alarm,
  input  logic        show_alarm_key,
  output logic [15:0] current_time,
  output logic [15:0] alarm_time,
  output logic        one_minute,
  output logic        show_alarm,
  output logic        entry_active,
  output logic [15:0] key_buffer
);

  localparam int unsigned PW = (CLKS_PER_MIN > 2) ? $clog2(CLKS_PER_MIN) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_MIN - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ENTRY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] prescale_q, prescale_d;
  logic [15:0]   time_q, time_d;
  logic [15:0]   alarm_q, alarm_d;
  logic [15:0]   buf_q, buf_d;
  logic          minute_q, minute_d;
  logic          show_q;

  logic tc;
  logic key_ok;
  logic buf_ok;

  // One-minute step of a packed BCD HHMM value, wrapping 23:59 to 00:00.
  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [3:0] ht, hu, mt, mu;
    {ht, hu, mt, mu} = t;
    if (mu != 4'd9) begin
      mu = mu + 4'd1;
    end else begin
      mu = 4'd0;
      if (mt != 4'd5) begin
        mt = mt + 4'd1;
      end else begin
        mt = 4'd0;
        if (ht == 4'd2 && hu == 4'd3) begin
          ht = 4'd0;
          hu = 4'd0;
        end else if (hu == 4'd9) begin
          hu = 4'd0;
          ht = ht + 4'd1;
        end else begin
          hu = hu + 4'd1;
        end
      end
    end
    return {ht, hu, mt, mu};
  endfunction

  assign tc     = (prescale_q == PRE_LAST);
  assign key_ok = key_valid && (key <= 4'd9);
  assign buf_ok = ((buf_q[15:12] < 4'd2) || (buf_q[15:12] == 4'd2 && buf_q[11:8] <= 4'd3))
                  && (buf_q[7:4] <= 4'd5);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prescale_q <= '0;
      time_q     <= 16'h0000;
      alarm_q    <= 16'h0000;
      buf_q      <= 16'h0000;
      minute_q   <= 1'b0;
      show_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prescale_q <= prescale_d;
      time_q     <= time_d;
      alarm_q    <= alarm_d;
      buf_q      <= buf_d;
      minute_q   <= minute_d;
      show_q     <= show_alarm_key;
    end
  end

  // Free-running timekeeping by default; a committed load_time overrides it.
  always_comb begin
    state_d    = state_q;
    prescale_d = tc ? '0 : prescale_q + PW'(1);
    time_d     = tc ? bcd_inc(time_q) : time_q;
    minute_d   = tc;
    alarm_d    = alarm_q;
    buf_d      = buf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (key_ok) begin
          buf_d   = {12'h000, key};
          state_d = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (load_time || load_alarm) begin
          buf_d   = 16'h0000;
          state_d = ST_IDLE;
          if (load_time && !load_alarm && buf_ok) begin
            time_d     = buf_q;
            prescale_d = '0;
            minute_d   = 1'b0;
          end else if (load_alarm && !load_time && buf_ok) begin
            alarm_d = buf_q;
          end
        end else if (key_ok) begin
          buf_d = {buf_q[11:0], key};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign current_time = time_q;
  assign alarm_time   = alarm_q;
  assign one_minute   = minute_q;
  assign show_alarm   = show_q;
  assign entry_active = (state_q == ST_ENTRY);
  assign key_buffer   = buf_q;

endmodule
